psx_ppb_scheduler: RTL and testbench

- Round-robin scheduler that sequences the shared Parallel Playstation Bus interface across four emulated controller ports.
- For each port with a pending command byte, it:
  - reads the command byte;
  - looks up the reply byte in the controller-state RAM at address {port, byte index};
  - writes that reply back with an ack pulse.
- Sits between `psx_ppb_interface` and the `sync_dualport_sram` read port. It replaces fixed-priority port selection with fair service plus a per-transaction timeout.

---
 rtl/psx_ppb_scheduler_pkg.sv | 23 ++
 rtl/psx_rr_picker4.sv | 35 +++
 rtl/psx_ppb_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_psx_ppb_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psx_ppb_scheduler_pkg.sv
// Shared definitions for the PPB round-robin scheduler: FSM state encoding,
// port/index/address geometry and a saturating counter helper.
package psx_ppb_scheduler_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;
    localparam int IDX_W     = 5;
    localparam int ADDR_W    = 7;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_READ_CMD    = 3'd1,
        S_FETCH       = 3'd2,
        S_LOAD        = 3'd3,
        S_WRITE_REPLY = 3'd4
    } state_e;

    // Increment an 8-bit event counter, sticking at all-ones.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/psx_rr_picker4.sv
// Four-way round-robin picker: rotates the request vector so the port after
// `last` sits at bit 0, priority-encodes it, then rotates the index back.
// `last` itself is only reached after the other three, so it wins only when
// it is the sole requester.
module psx_rr_picker4
    import psx_ppb_scheduler_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last,
    output logic [PORT_W-1:0]    grant,
    output logic                 valid
);

    logic [2*NUM_PORTS-1:0] dbl_s;
    logic [2:0]             shamt_s;
    logic [NUM_PORTS-1:0]   rot_s;
    logic [PORT_W-1:0]      off_s;

    // Rotate-and-priority-encode; purely combinational.
    always_comb begin
        dbl_s   = {req, req};
        shamt_s = {1'b0, last} + 3'd1;
        rot_s   = 4'(dbl_s >> shamt_s);
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        grant = last + 2'd1 + off_s;
        valid = |req;
    end

endmodule

// File: rtl/psx_ppb_scheduler.sv
// Round-robin scheduler for the shared Parallel Playstation Bus. Serves one
// pending command byte at a time: read command, fetch reply from state RAM at
// {port, index}, write reply with a one-cycle ack. Each bus wait is bounded
// by a timeout that abandons the transaction and counts the event.
module psx_ppb_scheduler
    import psx_ppb_scheduler_pkg::*;
#(
    parameter int CLOCK_MHZ  = 25,
    parameter int TIMEOUT_US = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ppb_irq_flags,
    input  logic [3:0]  port_enable,
    input  logic        ppb_done,
    input  logic [7:0]  ppb_command,
    input  logic [4:0]  ppb_index,
    output logic [1:0]  ppb_port,
    output logic        ppb_read,
    output logic        ppb_write,
    output logic        ppb_ack,
    output logic [7:0]  ppb_reply,
    output logic [6:0]  ram_addr,
    input  logic [7:0]  ram_data,
    output logic [7:0]  last_command,
    output logic        busy,
    output logic [7:0]  timeout_count
);

    localparam int TIMEOUT_CYCLES = CLOCK_MHZ * TIMEOUT_US;
    localparam int TMR_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

    state_e                state_q, state_d;
    logic [PORT_W-1:0]     last_port_q, last_port_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [PORT_W-1:0]     ppb_port_q, ppb_port_d;
    logic                  ppb_read_q, ppb_read_d;
    logic                  ppb_write_q, ppb_write_d;
    logic                  ppb_ack_q, ppb_ack_d;
    logic [7:0]            ppb_reply_q, ppb_reply_d;
    logic [ADDR_W-1:0]     ram_addr_q, ram_addr_d;
    logic [7:0]            last_command_q, last_command_d;
    logic                  busy_q, busy_d;
    logic [7:0]            timeout_count_q, timeout_count_d;

    logic [NUM_PORTS-1:0]  req_s;
    logic [PORT_W-1:0]     grant_s;
    logic                  grant_valid_s;

    assign req_s = ppb_irq_flags & port_enable;

    psx_rr_picker4 u_picker (
        .req   (req_s),
        .last  (last_port_q),
        .grant (grant_s),
        .valid (grant_valid_s)
    );

    // Next-state and output-register logic for the transaction sequencer.
    always_comb begin
        state_d         = state_q;
        last_port_d     = last_port_q;
        timer_d         = '0;
        ppb_port_d      = ppb_port_q;
        ppb_read_d      = ppb_read_q;
        ppb_write_d     = ppb_write_q;
        ppb_ack_d       = ppb_ack_q;
        ppb_reply_d     = ppb_reply_q;
        ram_addr_d      = ram_addr_q;
        last_command_d  = last_command_q;
        timeout_count_d = timeout_count_q;

        case (state_q)
            S_IDLE: begin
                ppb_read_d  = 1'b0;
                ppb_write_d = 1'b0;
                ppb_ack_d   = 1'b0;
                if (grant_valid_s) begin
                    ppb_port_d = grant_s;
                    ppb_read_d = 1'b1;
                    state_d    = S_READ_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ_CMD: begin
                if (ppb_done) begin
                    ppb_read_d     = 1'b0;
                    last_command_d = ppb_command;
                    ram_addr_d     = {ppb_port_q, ppb_index};
                    state_d        = S_FETCH;
                end else if (timer_q == TMR_LIMIT) begin
                    ppb_read_d      = 1'b0;
                    ppb_write_d     = 1'b0;
                    ppb_ack_d       = 1'b0;
                    timeout_count_d = sat_inc8(timeout_count_q);
                    last_port_d     = ppb_port_q;
                    state_d         = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            S_FETCH: begin
                // RAM address was registered last cycle; data lands next edge.
                state_d = S_LOAD;
            end
            S_LOAD: begin
                ppb_reply_d = ram_data;
                ppb_write_d = 1'b1;
                ppb_ack_d   = 1'b1;
                state_d     = S_WRITE_REPLY;
            end
            S_WRITE_REPLY: begin
                ppb_ack_d = 1'b0;
                if (ppb_done) begin
                    ppb_write_d = 1'b0;
                    last_port_d = ppb_port_q;
                    state_d     = S_IDLE;
                end else if (timer_q == TMR_LIMIT) begin
                    ppb_read_d      = 1'b0;
                    ppb_write_d     = 1'b0;
                    timeout_count_d = sat_inc8(timeout_count_q);
                    last_port_d     = ppb_port_q;
                    state_d         = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            default: begin
                ppb_read_d  = 1'b0;
                ppb_write_d = 1'b0;
                ppb_ack_d   = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset returns everything to idle with port 0 first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            last_port_q     <= 2'd3;
            timer_q         <= '0;
            ppb_port_q      <= 2'd0;
            ppb_read_q      <= 1'b0;
            ppb_write_q     <= 1'b0;
            ppb_ack_q       <= 1'b0;
            ppb_reply_q     <= 8'h00;
            ram_addr_q      <= 7'h00;
            last_command_q  <= 8'h00;
            busy_q          <= 1'b0;
            timeout_count_q <= 8'h00;
        end else begin
            state_q         <= state_d;
            last_port_q     <= last_port_d;
            timer_q         <= timer_d;
            ppb_port_q      <= ppb_port_d;
            ppb_read_q      <= ppb_read_d;
            ppb_write_q     <= ppb_write_d;
            ppb_ack_q       <= ppb_ack_d;
            ppb_reply_q     <= ppb_reply_d;
            ram_addr_q      <= ram_addr_d;
            last_command_q  <= last_command_d;
            busy_q          <= busy_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign ppb_port      = ppb_port_q;
    assign ppb_read      = ppb_read_q;
    assign ppb_write     = ppb_write_q;
    assign ppb_ack       = ppb_ack_q;
    assign ppb_reply     = ppb_reply_q;
    assign ram_addr      = ram_addr_q;
    assign last_command  = last_command_q;
    assign busy          = busy_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_psx_ppb_scheduler.sv
// Self-checking bench for psx_ppb_scheduler. Timeout is shortened to 25 cycles
// (25 MHz, 1 us). Expected grants, replies and timeout counts come from a
// small behavioural model: a round-robin scan over a request mask, a RAM
// array, and a saturating integer.
module tb_psx_ppb_scheduler;

    localparam int TO_CYC = 25;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] ppb_irq_flags = 4'h0;
    logic [3:0] port_enable = 4'h0;
    logic       ppb_done = 1'b0;
    logic [7:0] ppb_command = 8'h00;
    logic [4:0] ppb_index = 5'd0;
    logic [7:0] ram_data = 8'h00;
    logic [1:0] ppb_port;
    logic       ppb_read, ppb_write, ppb_ack, busy;
    logic [7:0] ppb_reply, last_command, timeout_count;
    logic [6:0] ram_addr;

    logic [7:0] mem [0:127];

    int n_cmp = 0;
    int n_err = 0;
    int m_last = 3;
    int m_to = 0;

    psx_ppb_scheduler #(.CLOCK_MHZ(25), .TIMEOUT_US(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .ppb_irq_flags (ppb_irq_flags),
        .port_enable   (port_enable),
        .ppb_done      (ppb_done),
        .ppb_command   (ppb_command),
        .ppb_index     (ppb_index),
        .ppb_port      (ppb_port),
        .ppb_read      (ppb_read),
        .ppb_write     (ppb_write),
        .ppb_ack       (ppb_ack),
        .ppb_reply     (ppb_reply),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .last_command  (last_command),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    // State RAM with one-cycle read latency.
    always @(posedge clk) ram_data <= mem[ram_addr];

    // First requesting port after `last`, scanning last+1 .. last+4.
    function automatic int model_winner(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (req[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        ppb_irq_flags = 4'h0;
        port_enable = 4'h0;
        ppb_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m_last = 3;
        m_to = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ppb_irq_flags = 4'h0;
        port_enable = 4'hF;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ppb_port, ppb_read, ppb_write, ppb_ack, ppb_reply, ram_addr, last_command, busy, timeout_count} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_outputs: port=%0d rd=%b wr=%b ack=%b reply=%h addr=%h cmd=%h busy=%b to=%0d, required all zero",
                     ppb_port, ppb_read, ppb_write, ppb_ack, ppb_reply, ram_addr, last_command, busy, timeout_count);
        end
        reset = 1'b1;
        m_last = 3;
        m_to = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || ppb_read !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: busy=%b read=%b, required 0 0", busy, ppb_read);
        end
    endtask

    // One complete transaction; rd_wait/wr_wait cycles of bus delay (< 25).
    task automatic run_txn(input logic [3:0] flags, input logic [3:0] en, input logic [4:0] idx,
                           input logic [7:0] cmd, input int rd_wait, input int wr_wait, output int port);
        int exp;
        logic [1:0] ep;
        logic [6:0] addr;
        logic [7:0] rep;
        ppb_irq_flags = flags;
        port_enable = en;
        ppb_done = 1'b0;
        exp = model_winner(flags & en, m_last);
        port = exp;
        ep = exp[1:0];
        addr = {ep, idx};
        rep = mem[addr];
        @(negedge clk);
        n_cmp++;
        if (ppb_read !== 1'b1 || ppb_port !== ep || busy !== 1'b1) begin
            n_err++;
            $display("FAIL grant: read=%b port=%0d busy=%b, required 1 %0d 1", ppb_read, ppb_port, busy, ep);
        end
        repeat (rd_wait) @(negedge clk);
        n_cmp++;
        if (ppb_read !== 1'b1) begin
            n_err++;
            $display("FAIL read_held: read=%b after %0d waits, required 1", ppb_read, rd_wait);
        end
        ppb_index = idx;
        ppb_command = cmd;
        ppb_done = 1'b1;
        @(negedge clk);
        ppb_done = 1'b0;
        ppb_command = ~cmd;
        ppb_index = ~idx;
        n_cmp++;
        if (ppb_read !== 1'b0 || ram_addr !== addr || last_command !== cmd || ppb_write !== 1'b0) begin
            n_err++;
            $display("FAIL cmd_capture: read=%b addr=%h cmd=%h write=%b, required 0 %h %h 0",
                     ppb_read, ram_addr, last_command, ppb_write, addr, cmd);
        end
        @(negedge clk);
        n_cmp++;
        if (ppb_write !== 1'b0 || ppb_ack !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_wait: write=%b ack=%b, required 0 0", ppb_write, ppb_ack);
        end
        @(negedge clk);
        n_cmp++;
        if (ppb_write !== 1'b1 || ppb_ack !== 1'b1 || ppb_reply !== rep) begin
            n_err++;
            $display("FAIL reply_start: write=%b ack=%b reply=%h, required 1 1 %h", ppb_write, ppb_ack, ppb_reply, rep);
        end
        for (int i = 0; i < wr_wait; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ppb_write !== 1'b1 || ppb_ack !== 1'b0 || ppb_reply !== rep) begin
                n_err++;
                $display("FAIL reply_hold: write=%b ack=%b reply=%h, required 1 0 %h", ppb_write, ppb_ack, ppb_reply, rep);
            end
        end
        ppb_done = 1'b1;
        @(negedge clk);
        ppb_done = 1'b0;
        m_last = exp;
        n_cmp++;
        if (ppb_write !== 1'b0 || ppb_ack !== 1'b0 || busy !== 1'b0 || timeout_count !== m_to[7:0] || last_command !== cmd) begin
            n_err++;
            $display("FAIL txn_end: write=%b ack=%b busy=%b to=%0d cmd=%h, required 0 0 0 %0d %h",
                     ppb_write, ppb_ack, busy, timeout_count, last_command, m_to, cmd);
        end
    endtask

    task automatic test_single();
        int p;
        mem[{2'd2, 5'd3}] = 8'h5A;
        run_txn(4'b0100, 4'hF, 5'd3, 8'h42, 1, 1, p);
        n_cmp++;
        if (ppb_port !== 2'd2 || ppb_reply !== 8'h5A || last_command !== 8'h42 || ram_addr !== 7'h43) begin
            n_err++;
            $display("FAIL single_txn: port=%0d reply=%h cmd=%h addr=%h, required 2 5a 42 43",
                     ppb_port, ppb_reply, last_command, ram_addr);
        end
    endtask

    task automatic test_fairness();
        int p;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            run_txn(4'hF, 4'hF, 5'($urandom), 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), p);
            n_cmp++;
            if (ppb_port !== 2'(i % 4)) begin
                n_err++;
                $display("FAIL fairness_order: txn %0d served port %0d, required %0d", i, ppb_port, i % 4);
            end
        end
    endtask

    task automatic test_masking();
        int p;
        for (int i = 0; i < 4; i++) begin
            run_txn(4'b0011, 4'b1110, 5'($urandom), 8'($urandom), 0, 0, p);
            n_cmp++;
            if (ppb_port !== 2'd1) begin
                n_err++;
                $display("FAIL masking: served port %0d, required 1", ppb_port);
            end
        end
    endtask

    task automatic test_random();
        int p;
        logic [3:0] f, e;
        for (int i = 0; i < 12; i++) begin
            e = 4'($urandom_range(1, 15));
            do f = 4'($urandom); while ((f & e) == 4'h0);
            run_txn(f, e, 5'($urandom), 8'($urandom), $urandom_range(0, 5), $urandom_range(0, 5), p);
        end
    endtask

    // ppb_done arriving on the very cycle the timer reaches its limit wins.
    task automatic test_done_at_limit();
        int p;
        run_txn(4'hF, 4'hF, 5'($urandom), 8'($urandom), TO_CYC - 1, TO_CYC - 1, p);
    endtask

    task automatic timeout_read(input logic [3:0] flags);
        int exp;
        int cnt;
        ppb_irq_flags = flags;
        port_enable = 4'hF;
        ppb_done = 1'b0;
        exp = model_winner(flags, m_last);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ppb_read === 1'b1) cnt++;
            else break;
        end
        m_to = (m_to < 255) ? m_to + 1 : 255;
        m_last = exp;
        n_cmp++;
        if (cnt !== TO_CYC || busy !== 1'b0 || timeout_count !== m_to[7:0] || ppb_port !== 2'(exp)) begin
            n_err++;
            $display("FAIL read_timeout: read_cycles=%0d busy=%b to=%0d port=%0d, required %0d 0 %0d %0d",
                     cnt, busy, timeout_count, ppb_port, TO_CYC, m_to, exp);
        end
    endtask

    task automatic timeout_write();
        int exp;
        int cnt;
        ppb_irq_flags = 4'hF;
        port_enable = 4'hF;
        exp = model_winner(4'hF, m_last);
        @(negedge clk);
        ppb_index = 5'd1;
        ppb_done = 1'b1;
        @(negedge clk);
        ppb_done = 1'b0;
        @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ppb_write === 1'b1) cnt++;
            else break;
        end
        m_to = (m_to < 255) ? m_to + 1 : 255;
        m_last = exp;
        n_cmp++;
        if (cnt !== TO_CYC || busy !== 1'b0 || ppb_ack !== 1'b0 || timeout_count !== m_to[7:0]) begin
            n_err++;
            $display("FAIL write_timeout: write_cycles=%0d busy=%b ack=%b to=%0d, required %0d 0 0 %0d",
                     cnt, busy, ppb_ack, timeout_count, TO_CYC, m_to);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] f;
        timeout_read(4'b0100);
        timeout_write();
        for (int i = 0; i < 300; i++) begin
            do f = 4'($urandom); while (f == 4'h0);
            timeout_read(f);
        end
        timeout_write();
        n_cmp++;
        if (timeout_count !== 8'd255) begin
            n_err++;
            $display("FAIL timeout_saturate: to=%0d, required 255", timeout_count);
        end
    endtask

    task automatic test_reset_mid();
        int p;
        ppb_irq_flags = 4'b0100;
        port_enable = 4'hF;
        @(negedge clk);
        ppb_done = 1'b1;
        ppb_index = 5'd7;
        @(negedge clk);
        ppb_done = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ppb_write !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_setup: write=%b, required 1", ppb_write);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (ppb_write !== 1'b0 || busy !== 1'b0 || timeout_count !== 8'd0 || ppb_port !== 2'd0) begin
            n_err++;
            $display("FAIL reset_mid_async: write=%b busy=%b to=%0d port=%0d, required 0 0 0 0",
                     ppb_write, busy, timeout_count, ppb_port);
        end
        @(negedge clk);
        reset = 1'b1;
        m_last = 3;
        m_to = 0;
        run_txn(4'hF, 4'hF, 5'd9, 8'h11, 0, 0, p);
        n_cmp++;
        if (ppb_port !== 2'd0) begin
            n_err++;
            $display("FAIL reset_mid_next_grant: port=%0d, required 0", ppb_port);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        test_reset();
        test_single();
        test_fairness();
        test_masking();
        test_random();
        test_done_at_limit();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
